rc4_sram_sched: RTL

- Phase sequencer and port owner for the single-port 256x8 S-array RAM used by the RC4 key-scheduling design.
- Three requester FSMs share the RAM in a fixed order. Client 0 is init (S[i]=i), client 1 is ksa (key-schedule swap), client 2 is prga (keystream/decrypt).
- This block starts each client in turn and muxes the owning client's address, data and wren onto the RAM through a registered stage.
- It returns read-valid strobes tagged to the client that issued each read.

---
 rtl/rc4_pkg.sv | 41 ++++
 rtl/rc4_rd_tag_pipe.sv | 30 +++
 rtl/rc4_sram_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 S-array scheduler and its read tag pipe.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_KSA  = 3'd2,
    ST_PRGA = 3'd3,
    ST_DONE = 3'd4
  } sched_state_t;

  localparam int NUM_CL  = 3;
  localparam int CL_INIT = 0;
  localparam int CL_KSA  = 1;
  localparam int CL_PRGA = 2;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  function automatic logic [1:0] phase_of(input sched_state_t s);
    case (s)
      ST_INIT: phase_of = PH_INIT;
      ST_KSA:  phase_of = PH_KSA;
      ST_PRGA: phase_of = PH_PRGA;
      default: phase_of = PH_IDLE;
    endcase
  endfunction

  // One-hot of the client owning the RAM in a given state; zero when nobody owns it.
  function automatic logic [NUM_CL-1:0] owner_of(input sched_state_t s);
    case (s)
      ST_INIT: owner_of = 3'b001;
      ST_KSA:  owner_of = 3'b010;
      ST_PRGA: owner_of = 3'b100;
      default: owner_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rc4_rd_tag_pipe.sv
// Delay line carrying {valid, client one-hot} from request time to the cycle
// the RAM read data is valid, so each read strobe returns to its issuer.
module rc4_rd_tag_pipe
  import rc4_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [NUM_CL-1:0] in_oh,
  output logic [NUM_CL-1:0] rvalid
);

  localparam int DEPTH = 1 + RD_LAT;

  logic [DEPTH-1:0][NUM_CL:0] pipe_r;

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_r <= {(DEPTH * (NUM_CL + 1)){1'b0}};
    end else begin
      pipe_r <= {pipe_r[DEPTH-2:0], {in_valid, in_oh}};
    end
  end

  assign rvalid = pipe_r[DEPTH-1][NUM_CL-1:0] & {NUM_CL{pipe_r[DEPTH-1][NUM_CL]}};

endmodule

// File: rtl/rc4_sram_sched.sv
// Phase sequencer and single-port S-array RAM owner for the RC4 engine.
// Define RC4_SCHED_PROTO_CHECK_EN to build the sticky protocol checker behind err.
module rc4_sram_sched
  import rc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               phase,
  output logic [NUM_CL-1:0]        cl_start,
  input  logic [NUM_CL-1:0]        cl_done,
  input  logic [NUM_CL-1:0]        cl_req,
  input  logic [NUM_CL-1:0]        cl_wren,
  input  logic [NUM_CL*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CL*DATA_W-1:0] cl_wdata,
  output logic [NUM_CL-1:0]        cl_rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     mem_wren,
  input  logic [DATA_W-1:0]        mem_q,
  output logic                     err
);

  sched_state_t      state_r;
  sched_state_t      state_nx_s;
  logic [NUM_CL-1:0] start_nx_s;
  logic [NUM_CL-1:0] cl_start_r;
  logic [1:0]        phase_r;
  logic              busy_r;
  logic              done_r;

  logic [NUM_CL-1:0] owner_oh_s;
  logic [ADDR_W-1:0] own_addr_s;
  logic [DATA_W-1:0] own_wdata_s;
  logic              own_wren_s;
  logic              start_cyc_s;
  logic              fwd_s;
  logic              rd_fire_s;

  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              mem_wren_r;

  // Phase sequencing: each client's done hands the RAM to the next client.
  always_comb begin
    state_nx_s = state_r;
    start_nx_s = 3'b000;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s = ST_INIT;
          start_nx_s = 3'b001;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_INIT: begin
        if (cl_done[CL_INIT]) begin
          state_nx_s = ST_KSA;
          start_nx_s = 3'b010;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      ST_KSA: begin
        if (cl_done[CL_KSA]) begin
          state_nx_s = ST_PRGA;
          start_nx_s = 3'b100;
        end else begin
          state_nx_s = ST_KSA;
        end
      end
      ST_PRGA: begin
        if (cl_done[CL_PRGA]) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_PRGA;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Select the owning client's access fields.
  always_comb begin
    owner_oh_s  = owner_of(state_r);
    own_addr_s  = {ADDR_W{1'b0}};
    own_wdata_s = {DATA_W{1'b0}};
    own_wren_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        own_addr_s  = cl_addr[CL_INIT*ADDR_W +: ADDR_W];
        own_wdata_s = cl_wdata[CL_INIT*DATA_W +: DATA_W];
        own_wren_s  = cl_wren[CL_INIT];
      end
      ST_KSA: begin
        own_addr_s  = cl_addr[CL_KSA*ADDR_W +: ADDR_W];
        own_wdata_s = cl_wdata[CL_KSA*DATA_W +: DATA_W];
        own_wren_s  = cl_wren[CL_KSA];
      end
      ST_PRGA: begin
        own_addr_s  = cl_addr[CL_PRGA*ADDR_W +: ADDR_W];
        own_wdata_s = cl_wdata[CL_PRGA*DATA_W +: DATA_W];
        own_wren_s  = cl_wren[CL_PRGA];
      end
      default: begin
        own_addr_s  = {ADDR_W{1'b0}};
        own_wdata_s = {DATA_W{1'b0}};
        own_wren_s  = 1'b0;
      end
    endcase
  end

  // The go-pulse cycle belongs to the client's own startup, so its requests wait a cycle.
  assign start_cyc_s = |(cl_start_r & owner_oh_s);
  assign fwd_s       = (|(cl_req & owner_oh_s)) & ~start_cyc_s;
  assign rd_fire_s   = fwd_s & ~own_wren_s;

  // State, status and RAM port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cl_start_r    <= 3'b000;
      phase_r       <= PH_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_data_r    <= {DATA_W{1'b0}};
      mem_wren_r    <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cl_start_r <= start_nx_s;
      phase_r    <= phase_of(state_nx_s);
      busy_r     <= (phase_of(state_nx_s) != PH_IDLE);
      done_r     <= (state_nx_s == ST_DONE);
      if (fwd_s) begin
        mem_address_r <= own_addr_s;
        mem_data_r    <= own_wdata_s;
        mem_wren_r    <= own_wren_s;
      end else begin
        mem_wren_r <= 1'b0;
      end
    end
  end

  rc4_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_fire_s),
    .in_oh    (owner_oh_s),
    .rvalid   (cl_rvalid)
  );

`ifdef RC4_SCHED_PROTO_CHECK_EN
  logic viol_s;
  logic err_r;

  // Flag requests or dones outside an owned phase, stray requests, and early owner requests.
  always_comb begin
    viol_s = 1'b0;
    if (owner_oh_s == 3'b000) begin
      viol_s = (|cl_req) | (|cl_done);
    end else begin
      viol_s = (|(cl_req & ~owner_oh_s)) | ((|(cl_req & owner_oh_s)) & start_cyc_s);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (viol_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign cl_start    = cl_start_r;
  assign phase       = phase_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;
  assign mem_wren    = mem_wren_r;
  assign rdata       = mem_q;

endmodule
